// File: rtl/path_follower.sv
// Buffers a planner path and issues one (from, to) hop per edge, waiting for arrival after each.
// Define PATH_REVERSE_EN to read the buffer LIFO (the planner emits the path goal-first).
module path_follower #(
    parameter int unsigned NODE_W    = 8,
    parameter int unsigned NUM_NODES = 37,
    parameter int unsigned DEPTH     = 38
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      path_valid_i,
    input  logic [NODE_W-1:0]         path_node_i,
    input  logic                      path_last_i,
    output logic                      path_ready_o,
    output logic                      cmd_valid_o,
    output logic [NODE_W-1:0]         cmd_from_o,
    output logic [NODE_W-1:0]         cmd_to_o,
    input  logic                      cmd_ready_i,
    input  logic                      arrived_i,
    input  logic                      abort_i,
    output logic [NODE_W-1:0]         cur_node_o,
    output logic [$clog2(DEPTH)-1:0]  hops_left_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitArr, StDone} state_e;

    state_e              state_q, state_d;
    logic [NODE_W-1:0]   buf_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
    logic [NODE_W-1:0]   cur_node_q, cur_node_d;
    logic [IdxW-1:0]     hops_q, hops_d;
    logic                err_q, err_d;
    logic                buf_we;
    logic                beat_bad;

    // A beat is bad if its index is out of range or it would not fit in the buffer.
    assign beat_bad = (path_node_i >= NODE_W'(NUM_NODES)) || (wr_ptr_q >= PtrW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        cur_node_d = cur_node_q;
        hops_d     = hops_q;
        err_d      = err_q;
        buf_we     = 1'b0;

        case (state_q)
            StIdle, StLoad: begin
                if (abort_i && state_q == StLoad) begin
                    state_d  = StIdle;
                    wr_ptr_d = '0;
                end else if (path_valid_i) begin
                    if (beat_bad) begin
                        err_d    = 1'b1;
                        state_d  = StIdle;
                        wr_ptr_d = '0;
                    end else begin
                        if (state_q == StIdle) begin
                            err_d = 1'b0;
                        end
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        state_d  = StLoad;
                        if (path_last_i) begin
                            hops_d   = IdxW'(wr_ptr_q);
                            wr_ptr_d = '0;
`ifdef PATH_REVERSE_EN
                            cur_node_d = path_node_i;
                            rd_idx_d   = IdxW'(wr_ptr_q) - IdxW'(1);
`else
                            cur_node_d = (wr_ptr_q == '0) ? path_node_i : buf_q[0];
                            rd_idx_d   = IdxW'(1);
`endif
                            state_d = (wr_ptr_q == '0) ? StDone : StIssue;
                        end
                    end
                end
            end
            StIssue: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (cmd_ready_i) begin
                    state_d = StWaitArr;
                end
            end
            StWaitArr: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (arrived_i) begin
                    cur_node_d = buf_q[rd_idx_q];
`ifdef PATH_REVERSE_EN
                    rd_idx_d   = rd_idx_q - IdxW'(1);
`else
                    rd_idx_d   = rd_idx_q + IdxW'(1);
`endif
                    hops_d     = hops_q - IdxW'(1);
                    state_d    = (hops_q == IdxW'(1)) ? StDone : StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            cur_node_q <= '0;
            hops_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            cur_node_q <= cur_node_d;
            hops_q     <= hops_d;
            err_q      <= err_d;
        end
    end

    // Path storage carries no control meaning, so it is left unreset.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            buf_q[IdxW'(wr_ptr_q)] <= path_node_i;
        end
    end

    always_comb begin
        path_ready_o = 1'b0;
        cmd_valid_o  = 1'b0;
        cmd_from_o   = '0;
        cmd_to_o     = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        cur_node_o   = '0;
        hops_left_o  = '0;
        err_o        = 1'b0;
        if (!reset_i) begin
            path_ready_o = (state_q == StIdle) || (state_q == StLoad);
            if (state_q == StIssue) begin
                cmd_valid_o = 1'b1;
                cmd_from_o  = cur_node_q;
                cmd_to_o    = buf_q[rd_idx_q];
            end
            busy_o      = (state_q == StIssue) || (state_q == StWaitArr) || (state_q == StDone);
            done_o      = (state_q == StDone) && !abort_i;
            cur_node_o  = cur_node_q;
            hops_left_o = hops_q;
            err_o       = err_q;
        end
    end

endmodule

// File: tb/tb_path_follower.sv
// Directed plus randomized checks of path_follower against a path-level hop model.
module tb_path_follower;

    localparam int unsigned NODE_W    = 8;
    localparam int unsigned NUM_NODES = 37;
    localparam int unsigned DEPTH     = 38;
    localparam int unsigned HopW      = $clog2(DEPTH);

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              path_valid_i = 1'b0;
    logic [NODE_W-1:0] path_node_i = '0;
    logic              path_last_i = 1'b0;
    logic              path_ready_o;
    logic              cmd_valid_o;
    logic [NODE_W-1:0] cmd_from_o;
    logic [NODE_W-1:0] cmd_to_o;
    logic              cmd_ready_i = 1'b0;
    logic              arrived_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [NODE_W-1:0] cur_node_o;
    logic [HopW-1:0]   hops_left_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int n_checks = 0;
    int n_fail   = 0;

    path_follower #(
        .NODE_W    (NODE_W),
        .NUM_NODES (NUM_NODES),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .path_valid_i (path_valid_i),
        .path_node_i  (path_node_i),
        .path_last_i  (path_last_i),
        .path_ready_o (path_ready_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_from_o   (cmd_from_o),
        .cmd_to_o     (cmd_to_o),
        .cmd_ready_i  (cmd_ready_i),
        .arrived_i    (arrived_i),
        .abort_i      (abort_i),
        .cur_node_o   (cur_node_o),
        .hops_left_o  (hops_left_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // path is in travel order; the expected hops are its consecutive pairs.
    task automatic run_path(input int path[$], input int arr_dly, input int stall,
                            input int abort_hop);
        int n;
        int beats[$];
        logic seen;
        n = path.size();
        beats = path;
`ifdef PATH_REVERSE_EN
        beats.reverse();
`endif
        cmd_ready_i = (stall == 0);
        for (int i = 0; i < n; i++) begin
            chk("load_ready", path_ready_o, 1);
            path_valid_i = 1'b1;
            path_node_i  = NODE_W'(beats[i]);
            path_last_i  = (i == n - 1);
            tick();
            if (i == 0) chk("err_clear", err_o, 0);
        end
        path_valid_i = 1'b0;
        path_last_i  = 1'b0;
        if (n == 1) begin
            chk("single_no_cmd", cmd_valid_o, 0);
            seen = done_o;
            if (!seen) begin
                tick();
                chk("single_no_cmd2", cmd_valid_o, 0);
                seen = done_o;
            end
            chk("single_done", seen, 1);
            chk("single_cur", cur_node_o, path[0]);
            tick();
            chk("single_done_off", done_o, 0);
            chk("single_ready_back", path_ready_o, 1);
            return;
        end
        for (int h = 0; h < n - 1; h++) begin
            chk("cmd_valid", cmd_valid_o, 1);
            chk("cmd_from", cmd_from_o, path[h]);
            chk("cmd_to", cmd_to_o, path[h + 1]);
            chk("busy", busy_o, 1);
            chk("hops_left", hops_left_o, n - 1 - h);
            chk("cur_before_hop", cur_node_o, path[h]);
            for (int s = 0; s < stall; s++) begin
                arrived_i = (s == 0);
                tick();
                arrived_i = 1'b0;
                chk("stall_valid", cmd_valid_o, 1);
                chk("stall_from", cmd_from_o, path[h]);
                chk("stall_to", cmd_to_o, path[h + 1]);
                chk("stall_hops", hops_left_o, n - 1 - h);
            end
            cmd_ready_i = 1'b1;
            tick();
            cmd_ready_i = (stall == 0);
            chk("cmd_drop", cmd_valid_o, 0);
            repeat (arr_dly - 1) tick();
            arrived_i = 1'b1;
            abort_i   = (h == abort_hop);
            tick();
            arrived_i = 1'b0;
            if (abort_i) begin
                abort_i = 1'b0;
                chk("abort_busy", busy_o, 0);
                chk("abort_cmd", cmd_valid_o, 0);
                chk("abort_done", done_o, 0);
                chk("abort_cur", cur_node_o, path[h]);
                chk("abort_ready", path_ready_o, 1);
                tick();
                chk("abort_no_done", done_o, 0);
                return;
            end
        end
        chk("done", done_o, 1);
        chk("final_cur", cur_node_o, path[n - 1]);
        chk("final_hops", hops_left_o, 0);
        chk("done_no_ready", path_ready_o, 0);
        tick();
        chk("done_off", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_ready", path_ready_o, 1);
    endtask

    initial begin
        int tp[$];
        int one[$];
        int rp[$];
        int len;
        tp  = '{33, 31, 28, 21, 18, 11, 4, 2, 3};
        one = '{7};

        // reset: every output held low
        tick();
        tick();
        chk("rst_ready", path_ready_o, 0);
        chk("rst_cmd", cmd_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cur", cur_node_o, 0);
        chk("rst_hops", hops_left_o, 0);
        reset_i = 1'b0;
        tick();
        chk("post_rst_ready", path_ready_o, 1);

        run_path(tp, 3, 0, -1);
        run_path(one, 1, 0, -1);

        // out-of-range node mid-load
        path_valid_i = 1'b1;
        path_node_i = 8'd33; tick();
        path_node_i = 8'd31; tick();
        path_node_i = 8'd40; tick();
        path_valid_i = 1'b0;
        chk("bad_err", err_o, 1);
        chk("bad_idle_ready", path_ready_o, 1);
        chk("bad_busy", busy_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bad_no_cmd", cmd_valid_o, 0);
            chk("bad_err_sticky", err_o, 1);
        end
        run_path(tp, 2, 0, -1);

        // abort together with arrived on hop 3
        run_path(tp, 3, 0, 2);

        // cmd_ready held low for 5 cycles per hop
        run_path(tp, 1, 5, -1);

        // overflow: DEPTH+1 beats with no path_last
        path_valid_i = 1'b1;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            chk("ovf_ready", path_ready_o, 1);
            path_node_i = NODE_W'(i % int'(NUM_NODES));
            tick();
        end
        path_valid_i = 1'b0;
        chk("ovf_err", err_o, 1);
        chk("ovf_busy", busy_o, 0);
        tick();
        chk("ovf_no_cmd", cmd_valid_o, 0);

        // full-depth path
        rp.delete();
        for (int i = 0; i < int'(DEPTH); i++) rp.push_back(int'($urandom_range(0, NUM_NODES - 1)));
        run_path(rp, 1, 0, -1);

        for (int t = 0; t < 8; t++) begin
            rp.delete();
            len = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < len; i++) rp.push_back(int'($urandom_range(0, NUM_NODES - 1)));
            run_path(rp, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
